// File: rtl/rr_arbiter4.sv
// Purpose: 4-requester round-robin arbiter with grant hold and a MAX_HOLD revocation limit.
// Latency: one cycle from req sampled at an edge to grant visible after that edge.
// Backpressure: none; requesters hold req high until granted and keep it high while using the resource.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          asynchronous active-high reset
//   req[3:0]     level-sensitive request lines, req[i]=1 means requester i wants the resource
//   grant[3:0]   registered grant, always one-hot or all-zero, drives the owner encoder directly
//   grant_valid  registered, equal to the OR of grant every cycle
//   timeout      registered one-cycle pulse when a grant is revoked by hold expiry
//
// Parameters:
//   MAX_HOLD     maximum consecutive cycles one owner keeps the grant while it still requests (1..255)
//   CNT_W        hold counter width, 2**CNT_W must exceed MAX_HOLD

module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,       state_d;
    logic [3:0]       grant_q,       grant_d;
    logic             grant_valid_q, grant_valid_d;
    logic             timeout_q,     timeout_d;
    logic [1:0]       ptr_q,         ptr_d;
    logic [CNT_W-1:0] hold_cnt_q,    hold_cnt_d;

    // ------------------------------------------------------------------
    // Current owner index. grant_q is guaranteed one-hot or zero, so the
    // default arm is only reached for the all-zero case, which is never
    // consulted outside GRANT.
    // ------------------------------------------------------------------
    logic [1:0] owner_idx;

    always_comb begin
        owner_idx = 2'd0;
        case (grant_q)
            4'b0001: owner_idx = 2'd0;
            4'b0010: owner_idx = 2'd1;
            4'b0100: owner_idx = 2'd2;
            4'b1000: owner_idx = 2'd3;
            default: owner_idx = 2'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Rotating priority search. In IDLE the search starts at ptr_q; in
    // GRANT it only matters on release or expiry, and both of those start
    // one past the owner, so the owner (if still requesting) ranks last.
    // ------------------------------------------------------------------
    logic [1:0] search_start;
    logic [1:0] cand_idx;
    logic [1:0] win_idx;
    logic       win_found;

    assign search_start = (state_q == IDLE) ? ptr_q : (owner_idx + 2'd1);

    // Walk the candidates from lowest priority to highest so the last
    // assignment left standing is the highest-priority requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand_idx  = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand_idx = search_start + 2'(k);
            if (req[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    logic [3:0] win_onehot;
    assign win_onehot = 4'b0001 << win_idx;

    logic owner_req;
    logic hold_expired;

    assign owner_req    = req[owner_idx];
    assign hold_expired = (hold_cnt_q == CNT_W'(MAX_HOLD));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // ptr is deliberately left alone here so the next search
                // after an idle gap still starts one past the last owner.
                if (win_found) begin
                    grant_d    = win_onehot;
                    hold_cnt_d = CNT_W'(1);
                    state_d    = GRANT;
                end else begin
                    grant_d    = 4'b0000;
                    hold_cnt_d = '0;
                end
            end

            GRANT: begin
                if (!owner_req) begin
                    // Release: hand over in the same edge when anyone else
                    // is waiting, so there is no idle bubble between owners.
                    ptr_d = owner_idx + 2'd1;
                    if (win_found) begin
                        grant_d    = win_onehot;
                        hold_cnt_d = CNT_W'(1);
                    end else begin
                        grant_d    = 4'b0000;
                        hold_cnt_d = '0;
                        state_d    = IDLE;
                    end
                end else if (hold_expired) begin
                    // Expiry: the owner is still requesting, so the search
                    // always finds someone; a sole requester wins itself back
                    // and the counter restarts, keeping hold_cnt bounded.
                    timeout_d  = 1'b1;
                    ptr_d      = owner_idx + 2'd1;
                    grant_d    = win_onehot;
                    hold_cnt_d = CNT_W'(1);
                end else begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d    = IDLE;
                grant_d    = 4'b0000;
                hold_cnt_d = '0;
            end
        endcase
    end

    // grant_valid is registered from the same next-state value as grant so
    // the two can never disagree.
    assign grant_valid_d = |grant_d;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            ptr_q         <= 2'd0;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
module tb_rr_arbiter4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grant_valid;
    logic       timeout;

    int n_checks;
    int n_errors;

    rr_arbiter4 #(
        .MAX_HOLD (8),
        .CNT_W    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock: inputs applied before the edge, outputs
    // expected just after it.
    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic       exp_to;
        string      tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                       input logic t, input string tag);
        vec_t v;
        v.rst       = r;
        v.req       = rq;
        v.exp_grant = g;
        v.exp_to    = t;
        v.tag       = tag;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int idx,
                                 input logic [3:0] g, input logic t);
        check({tag, ".grant"},       idx, grant,                g);
        check({tag, ".grant_valid"}, idx, {3'b000, grant_valid}, {3'b000, (g != 4'b0000)});
        check({tag, ".timeout"},     idx, {3'b000, timeout},     {3'b000, t});
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;

        // ---------------- vector table ----------------
        // single request after reset, then release
        add(0, 4'b0100, 4'b0100, 0, "single");
        add(0, 4'b0100, 4'b0100, 0, "single");
        add(0, 4'b0000, 4'b0000, 0, "single_drop");

        // simultaneous requests from reset, each owner releases after 2 cycles
        add(1, 4'b0000, 4'b0000, 0, "rst");
        add(0, 4'b1111, 4'b0001, 0, "rr");
        add(0, 4'b1111, 4'b0001, 0, "rr");
        add(0, 4'b1110, 4'b0010, 0, "rr");
        add(0, 4'b1111, 4'b0010, 0, "rr");
        add(0, 4'b1101, 4'b0100, 0, "rr");
        add(0, 4'b1111, 4'b0100, 0, "rr");
        add(0, 4'b1011, 4'b1000, 0, "rr");
        add(0, 4'b1111, 4'b1000, 0, "rr");
        add(0, 4'b0111, 4'b0001, 0, "rr_wrap");
        add(0, 4'b0000, 4'b0000, 0, "rr_idle");

        // hold expiry between two constant requesters
        add(1, 4'b0000, 4'b0000, 0, "rst");
        for (int i = 0; i < 8; i++) add(0, 4'b0011, 4'b0001, 0, "exp_a");
        add(0, 4'b0011, 4'b0010, 1, "exp_switch_b");
        for (int i = 0; i < 7; i++) add(0, 4'b0011, 4'b0010, 0, "exp_b");
        add(0, 4'b0011, 4'b0001, 1, "exp_switch_a");
        add(0, 4'b0000, 4'b0000, 0, "exp_idle");

        // sole requester: regranted on every expiry, timeout still pulses
        for (int i = 1; i <= 20; i++)
            add(0, 4'b1000, 4'b1000, (i == 9 || i == 17) ? 1'b1 : 1'b0, "sole");
        add(0, 4'b0000, 4'b0000, 0, "sole_idle");

        // pointer remembered across idle: last owner 1 -> search from 2
        add(0, 4'b0010, 4'b0010, 0, "ptr");
        add(0, 4'b0000, 4'b0000, 0, "ptr_idle");
        add(0, 4'b0011, 4'b0001, 0, "ptr_wrap");
        add(0, 4'b0000, 4'b0000, 0, "ptr_idle2");

        // non-owner toggles during a grant are ignored
        add(0, 4'b0010, 4'b0010, 0, "toggle");
        add(0, 4'b0110, 4'b0010, 0, "toggle");
        add(0, 4'b0011, 4'b0010, 0, "toggle");
        add(0, 4'b0001, 4'b0001, 0, "toggle_rel");
        add(0, 4'b0000, 4'b0000, 0, "toggle_idle");

        // ---------------- reset state ----------------
        rst = 1'b1;
        req = 4'b0000;
        #2;
        check_outputs("reset", -1, 4'b0000, 1'b0);

        // ---------------- table ----------------
        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            req = vecs[i].req;
            @(posedge clk);
            #1;
            check_outputs(vecs[i].tag, i, vecs[i].exp_grant, vecs[i].exp_to);
        end

        // ---------------- async reset mid-grant ----------------
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 4'b0100;
        @(posedge clk);
        #1;
        check_outputs("arst_pre", 0, 4'b0100, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check_outputs("arst_now", 1, 4'b0000, 1'b0);
        req = 4'b0110;
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("arst_after", 2, 4'b0010, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
